// File: rtl/ntt_pkg.sv
// Shared types and defaults for the NTT butterfly-schedule controller.
// Holds the FSM state encoding, default sizes and the stage-index width helper.
package ntt_pkg;

    localparam int unsigned LOGN_DEF    = 8;
    localparam int unsigned BFU_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_e;

    // Width of the stage index; never narrower than one bit.
    function automatic int unsigned stage_w(input int unsigned logn);
        return (logn > 1) ? $clog2(logn) : 1;
    endfunction

endpackage

// File: rtl/ntt_ctrl_if.sv
// Control/status bundle between the NTT controller (master) and the memory/BFU side (slave).
interface ntt_ctrl_if import ntt_pkg::*; #(
    parameter int unsigned LOGN = LOGN_DEF
);
    localparam int unsigned SW = stage_w(LOGN);

    logic            i_start;
    logic            i_bfu_valid;
    logic            o_busy;
    logic            o_rd_en;
    logic [LOGN-1:0] o_rd_addr_x;
    logic [LOGN-1:0] o_rd_addr_y;
    logic [LOGN-1:0] o_tw_addr;
    logic            o_bfu_en;
    logic            o_wr_en;
    logic [LOGN-1:0] o_wr_addr_x;
    logic [LOGN-1:0] o_wr_addr_y;
    logic [SW-1:0]   o_stage;
    logic            o_done;
    logic            o_err;

    modport master (
        input  i_start, i_bfu_valid,
        output o_busy, o_rd_en, o_rd_addr_x, o_rd_addr_y, o_tw_addr, o_bfu_en,
               o_wr_en, o_wr_addr_x, o_wr_addr_y, o_stage, o_done, o_err
    );

    modport slave (
        output i_start, i_bfu_valid,
        input  o_busy, o_rd_en, o_rd_addr_x, o_rd_addr_y, o_tw_addr, o_bfu_en,
               o_wr_en, o_wr_addr_x, o_wr_addr_y, o_stage, o_done, o_err
    );

endinterface

// File: rtl/ntt_delay_line.sv
// Resettable shift register that replays each issued read {valid, x, y} as the
// butterfly enable (first tap) and as the write-back strobe/addresses (last tap).
module ntt_delay_line #(
    parameter int unsigned LOGN  = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    input  logic [LOGN-1:0] i_addr_x,
    input  logic [LOGN-1:0] i_addr_y,
    output logic            o_bfu_en,
    output logic            o_wr_en,
    output logic [LOGN-1:0] o_wr_addr_x,
    output logic [LOGN-1:0] o_wr_addr_y
);

    logic [DEPTH-1:0][2*LOGN:0] r_pipe;

    // Shift one slot per cycle; reset flushes any in-flight write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= {i_valid, i_addr_x, i_addr_y};
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_bfu_en    = r_pipe[0][2*LOGN];
    assign o_wr_en     = r_pipe[DEPTH-1][2*LOGN];
    assign o_wr_addr_x = r_pipe[DEPTH-1][2*LOGN-1:LOGN];
    assign o_wr_addr_y = r_pipe[DEPTH-1][LOGN-1:0];

endmodule

// File: rtl/ntt_ctrl.sv
// Forward-NTT schedule controller: issues N/2 butterflies per stage, drains the
// BFU pipeline between stages. Optional bfu_valid alignment check: NTT_CTRL_VALID_CHECK_EN.
module ntt_ctrl import ntt_pkg::*; #(
    parameter int unsigned LOGN    = LOGN_DEF,
    parameter int unsigned BFU_LAT = BFU_LAT_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    ntt_ctrl_if.master bus
);

    localparam int unsigned SW = stage_w(LOGN);
    localparam int unsigned CW = (LOGN > $clog2(BFU_LAT + 1)) ? LOGN : $clog2(BFU_LAT + 1);
    localparam logic [CW-1:0] LAST_ISSUE = CW'((2 ** (LOGN - 1)) - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(BFU_LAT);
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOGN - 1);

    ntt_state_e      r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [SW-1:0]   r_stage, w_stage_nxt;
    logic            r_rd_en, r_busy, r_done;
    logic [LOGN-1:0] r_rd_addr_x, r_rd_addr_y, r_tw_addr;
    logic [SW-1:0]   w_shift;
    logic [LOGN-1:0] w_half, w_pair, w_grp, w_ax, w_ay, w_tw;
    logic            w_wr_en;

    // State, counter and stage registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_stage <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stage <= w_stage_nxt;
        end
    end

    // Next-state logic; r_cnt counts issues in ISSUE and drain cycles in DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stage_nxt = r_stage;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_state_nxt = ST_ISSUE;
                    w_cnt_nxt   = '0;
                    w_stage_nxt = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (r_cnt == LAST_ISSUE) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1'b1);
                end
            end
            ST_DRAIN: begin
                if (r_cnt == LAST_DRAIN) begin
                    w_cnt_nxt = '0;
                    if (r_stage == LAST_STAGE) begin
                        w_state_nxt = ST_DONE;
                        w_stage_nxt = '0;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_stage_nxt = r_stage + SW'(1'b1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1'b1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_stage_nxt = '0;
            end
        endcase
    end

    // Pair address = issue index with a zero inserted at bit (LOGN-1-stage).
    always_comb begin
        w_shift = SW'(LOGN - 1) - w_stage_nxt;
        w_half  = LOGN'(1'b1) << w_shift;
        w_pair  = w_cnt_nxt[LOGN-1:0];
        w_grp   = w_pair >> w_shift;
        if (w_state_nxt == ST_ISSUE) begin
            w_ax = ((w_grp << w_shift) << 1) | (w_pair & (w_half - LOGN'(1'b1)));
            w_ay = w_ax | w_half;
            w_tw = (LOGN'(1'b1) << w_stage_nxt) | w_grp;
        end else begin
            w_ax = '0;
            w_ay = '0;
            w_tw = '0;
        end
    end

    // Registered read-side and status outputs, aligned with the state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_en     <= 1'b0;
            r_rd_addr_x <= '0;
            r_rd_addr_y <= '0;
            r_tw_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rd_en     <= (w_state_nxt == ST_ISSUE);
            r_rd_addr_x <= w_ax;
            r_rd_addr_y <= w_ay;
            r_tw_addr   <= w_tw;
            r_busy      <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    ntt_delay_line #(
        .LOGN  (LOGN),
        .DEPTH (1 + BFU_LAT)
    ) u_delay (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (r_rd_en),
        .i_addr_x    (r_rd_addr_x),
        .i_addr_y    (r_rd_addr_y),
        .o_bfu_en    (bus.o_bfu_en),
        .o_wr_en     (w_wr_en),
        .o_wr_addr_x (bus.o_wr_addr_x),
        .o_wr_addr_y (bus.o_wr_addr_y)
    );

`ifdef NTT_CTRL_VALID_CHECK_EN
    logic r_err;

    // Sticky flag: BFU valid must track the write-back strobe exactly.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if (bus.i_bfu_valid != w_wr_en) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign bus.o_err = r_err;
`else
    logic w_unused_bfu_valid;
    assign w_unused_bfu_valid = bus.i_bfu_valid;
    assign bus.o_err          = 1'b0;
`endif

    assign bus.o_busy      = r_busy;
    assign bus.o_rd_en     = r_rd_en;
    assign bus.o_rd_addr_x = r_rd_addr_x;
    assign bus.o_rd_addr_y = r_rd_addr_y;
    assign bus.o_tw_addr   = r_tw_addr;
    assign bus.o_wr_en     = w_wr_en;
    assign bus.o_stage     = r_stage;
    assign bus.o_done      = r_done;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl at LOGN=3, BFU_LAT=2: per-cycle compare against a
// hand-written address table and a cycle-indexed schedule.
module tb_ntt_ctrl;
    import ntt_pkg::*;

    localparam int unsigned LOGN    = 3;
    localparam int unsigned BFU_LAT = 2;
    localparam int NH     = 4;
    localparam int PER    = NH + 1 + BFU_LAT;
    localparam int DONE_T = int'(LOGN) * PER + 1;

`ifdef NTT_CTRL_VALID_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ntt_ctrl_if #(.LOGN(LOGN)) bus ();

    ntt_ctrl #(.LOGN(LOGN), .BFU_LAT(BFU_LAT)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Hand-computed pairs and twiddles for stages 0..2, four butterflies each.
    int tx  [12] = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
    int ty  [12] = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
    int ttw [12] = '{1, 1, 1, 1,  2, 2, 3, 3,  4, 5, 6, 7};

    int checks   = 0;
    int failures = 0;
    int t_m      = 0;
    bit e_err    = 1'b0;
    bit prev_ew  = 1'b0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, got, exp, t_m, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs, advance the model.
    task automatic step(input bit st, input bit rs, input bit late);
        int s, u, k;
        bit e_rd, e_bfu, e_wr, e_busy, e_done, bv;
        int e_rx, e_ry, e_tw, e_wx, e_wy, e_stg;
        e_rd = 0; e_bfu = 0; e_wr = 0; e_busy = 0; e_done = 0;
        e_rx = 0; e_ry = 0; e_tw = 0; e_wx = 0; e_wy = 0; e_stg = 0;
        if (t_m >= 1 && t_m < DONE_T) begin
            s = (t_m - 1) / PER;
            u = (t_m - 1) % PER;
            e_busy = 1;
            e_stg  = s;
            if (u < NH) begin
                k = s * NH + u;
                e_rd = 1; e_rx = tx[k]; e_ry = ty[k]; e_tw = ttw[k];
            end
            if (u >= 1 && u <= NH) e_bfu = 1;
            if (u >= 1 + int'(BFU_LAT)) begin
                k = s * NH + u - 1 - int'(BFU_LAT);
                e_wr = 1; e_wx = tx[k]; e_wy = ty[k];
            end
        end
        if (t_m == DONE_T) e_done = 1;
        bv = late ? prev_ew : e_wr;
        bus.i_start     = st;
        bus.i_bfu_valid = bv;
        rst             = rs;
        check_val("rd_en",     int'(bus.o_rd_en),     int'(e_rd));
        check_val("rd_addr_x", int'(bus.o_rd_addr_x), e_rx);
        check_val("rd_addr_y", int'(bus.o_rd_addr_y), e_ry);
        check_val("tw_addr",   int'(bus.o_tw_addr),   e_tw);
        check_val("bfu_en",    int'(bus.o_bfu_en),    int'(e_bfu));
        check_val("wr_en",     int'(bus.o_wr_en),     int'(e_wr));
        check_val("wr_addr_x", int'(bus.o_wr_addr_x), e_wx);
        check_val("wr_addr_y", int'(bus.o_wr_addr_y), e_wy);
        check_val("busy",      int'(bus.o_busy),      int'(e_busy));
        check_val("done",      int'(bus.o_done),      int'(e_done));
        check_val("stage",     int'(bus.o_stage),     e_stg);
        check_val("err",       int'(bus.o_err),       int'(CHK_EN & e_err));
        if (bus.o_wr_en) wr_cnt++;
        if (bus.o_done) done_cnt++;
        prev_ew = e_wr;
        @(posedge clk);
        #1;
        if (rs) begin
            e_err = 1'b0;
            t_m   = 0;
        end else begin
            if (bv != e_wr) e_err = 1'b1;
            if (t_m == 0) t_m = st ? 1 : 0;
            else if (t_m == DONE_T) t_m = 0;
            else t_m++;
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_bfu_valid = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Full run; extra start pulses during ISSUE and in DONE are ignored.
        wr_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 26; c++) step(c == 0 || c == 5 || c == 22, 1'b0, 1'b0);
        check_val("wr_total",   wr_cnt,   12);
        check_val("done_total", done_cnt, 1);

        // Held start re-triggers only once IDLE is re-entered.
        for (int c = 0; c < 50; c++) step(c <= 26, 1'b0, 1'b0);

        // Reset mid-transform, then a clean run.
        for (int c = 0; c < 15; c++) step(c == 0, c == 10, 1'b0);
        wr_cnt = 0;
        for (int c = 0; c < 26; c++) step(c == 0, 1'b0, 1'b0);
        check_val("wr_after_rst", wr_cnt, 12);

        // bfu_valid one cycle late, then reset clears err.
        for (int c = 0; c < 26; c++) step(c == 0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 Parameter LOGN, default 8: log2 of transform size N; N = 2^LOGN coefficients.
REQ-002 Parameter BFU_LAT, default 2: butterfly-unit cycles from its en to its valid.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request one full forward transform; sampled only in IDLE.
REQ-006 bfu_valid  in  1  valid strobe from the butterfly unit; used only by the REQ-027 check.
REQ-007 busy  out  1  high from the cycle after start is accepted until done.
REQ-008 rd_en  out  1  coefficient-memory read strobe for one x/y pair.
REQ-009 rd_addr_x, rd_addr_y  out  LOGN each  pair addresses; memory read latency is 1 cycle.
REQ-010 tw_addr  out  LOGN  twiddle-ROM address, issued with rd_en.
REQ-011 bfu_en  out  1  butterfly enable; rd_en delayed 1 cycle.
REQ-012 wr_en  out  1  write-back strobe for xout/yout.
REQ-013 wr_addr_x, wr_addr_y  out  LOGN each  write-back addresses.
REQ-014 stage  out  clog2(LOGN)  current stage index.
REQ-015 done  out  1  single-cycle completion pulse.
REQ-016 err  out  1  sticky valid-alignment error (REQ-027).

Function
REQ-017 States: IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on start; ISSUE->DRAIN after N/2 issues; DRAIN->ISSUE (stage+1) or DONE (last stage) once the last write of the stage has completed; DONE->IDLE after 1 cycle.
REQ-018 Start accepted at edge k: first ISSUE cycle is k+1, with rd_en high and stage=0.
REQ-019 ISSUE: rd_en high on N/2 consecutive cycles, one butterfly per cycle, no gaps.
REQ-020 Stage s: half-span L = 2^(LOGN-1-s); group g in 0..2^s-1, j in 0..L-1, g outer, j inner; rd_addr_x = 2*L*g + j; rd_addr_y = rd_addr_x + L; tw_addr = 2^s + g.
REQ-021 bfu_en is asserted exactly 1 cycle after rd_en; wr_en plus the matching wr_addr_x/y exactly 1+BFU_LAT cycles after rd_en.
REQ-022 Next stage's first rd_en is issued on the cycle after the previous stage's last wr_en; no read-after-write overlap.
REQ-023 done is high on the cycle after the final wr_en; busy falls in the same cycle.
REQ-024 start while busy, or in DONE, is ignored; start held high re-triggers only from IDLE.
REQ-025 When idle, all address outputs are 0 and rd_en, bfu_en and wr_en are low.

Reset
REQ-026 reset, including mid-transform, forces IDLE and clears the delay line, counters and err; every output is 0 on the next cycle and no in-flight wr_en is emitted.

Configuration
REQ-027 With NTT_CTRL_VALID_CHECK_EN defined, err sets when bfu_valid differs from the expected internal strobe (rd_en delayed 1+BFU_LAT) and holds until reset; without it, err is constant 0 and bfu_valid is unused.

Structure
REQ-028 Package ntt_pkg holds the state enum, default LOGN/BFU_LAT and the stage-width function.
REQ-029 Sub-module ntt_delay_line: a shift register, depth 1+BFU_LAT, carrying {valid, addr_x, addr_y}; it is resettable and generates wr_en/wr_addr.

Verification (LOGN=3, BFU_LAT=2)
REQ-030 Start at cycle 0 -> stage 0: rd pairs (0,4),(1,5),(2,6),(3,7) at cycles 1-4, tw_addr 1; wr_en at cycles 4-7 with the same pairs.
REQ-031 Stage 1 -> first rd at cycle 8: (0,2),(1,3) tw 2, then (4,6),(5,7) tw 3; stage 2 -> (0,1) tw4, (2,3) tw5, (4,5) tw6, (6,7) tw7.
REQ-032 Full run -> done at cycle 22 only (one cycle wide), busy high on cycles 1-21, 12 wr_en pulses total.
REQ-033 start pulsed at cycle 5 and start held high -> no restart before DONE; held start gives the next first rd_en the cycle after IDLE is re-entered.
REQ-034 reset at cycle 10 -> all outputs 0 at cycle 11, no wr_en afterwards, a new start runs cleanly.
REQ-035 With the macro defined, bfu_valid driven one cycle late -> err=1 from the first mismatch until reset; without the macro -> err stays 0.
